// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants, state encoding and frame helpers
package spi_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam int         SPI_FRAME_BITS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } spi_state_e;

  // Data phase is little-endian by byte on the wire, each byte MSB-first.
  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(
      input logic        we,
      input logic [21:0] word_addr,
      input logic [31:0] wdata);
    return {we ? SPI_CMD_WRITE : SPI_CMD_READ, word_addr, 2'b00,
            we ? bswap32(wdata) : 32'h0};
  endfunction

endpackage

// File: rtl/spi_data_port_if.sv
// rtl/spi_data_port_if.sv - core-side request/response bus of the SPI data port
interface spi_data_port_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, done, busy);
  modport slave  (input req, we, addr, wdata, output rdata, done, busy);
endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - divided SCLK with single-cycle rise/fall strobes
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  // Strobes mark the clk cycle whose closing edge toggles sclk.
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_data_port.sv
// rtl/spi_data_port.sv - word load/store port to an SPI mode-0 memory
module spi_data_port
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_data_port_if.slave   bus,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  spi_state_e                 state;
  logic [SPI_FRAME_BITS-1:0]  shreg;
  logic [31:0]                rx;
  logic [6:0]                 bitcnt;
  logic [CW-1:0]              hold_cnt;
  logic                       we_q;
  logic                       rise;
  logic                       fall;
  logic                       addr_unused;

  assign addr_unused = ^{bus.addr[31:24], bus.addr[1:0]};

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .sclk (sclk),
    .rise (rise),
    .fall (fall)
  );

  // cs_n decodes from state so an async reset releases the bus at once.
  assign cs_n     = !(state == SHIFT || state == HOLD);
  assign mosi     = shreg[SPI_FRAME_BITS-1];
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      rx        <= '0;
      bitcnt    <= '0;
      hold_cnt  <= '0;
      we_q      <= 1'b0;
      bus.rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            shreg  <= build_frame(bus.we, bus.addr[23:2], bus.wdata);
            we_q   <= bus.we;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Only the last 32 captured bits survive, so command/address
          // phase miso is dropped without a separate phase check.
          if (rise) rx <= {rx[30:0], miso};
          if (fall) begin
            shreg  <= {shreg[SPI_FRAME_BITS-2:0], 1'b0};
            bitcnt <= bitcnt + 7'd1;
            if (bitcnt == 7'd63) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == CW'(CLK_DIV - 1)) begin
            if (!we_q) bus.rdata <= bswap32(rx);
            state <= DONE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_data_port.sv
// tb/tb_spi_data_port.sv - directed bench for spi_data_port at CLK_DIV 2 and 1
module tb_spi_data_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_data_port_if bus_a ();
  spi_data_port_if bus_b ();

  logic [1:0]  sclk;
  logic [1:0]  cs_n;
  logic [1:0]  mosi;
  logic [1:0]  miso = 2'b00;
  logic        req_v   [2] = '{1'b0, 1'b0};
  logic        we_v    [2] = '{1'b0, 1'b0};
  logic [31:0] addr_v  [2] = '{32'h0, 32'h0};
  logic [31:0] wdata_v [2] = '{32'h0, 32'h0};
  logic [63:0] resp    [2] = '{64'h0, 64'h0};
  logic        done_w  [2];
  logic        busy_a;
  logic [31:0] rdata_w [2];

  assign bus_a.req   = req_v[0];
  assign bus_a.we    = we_v[0];
  assign bus_a.addr  = addr_v[0];
  assign bus_a.wdata = wdata_v[0];
  assign bus_b.req   = req_v[1];
  assign bus_b.we    = we_v[1];
  assign bus_b.addr  = addr_v[1];
  assign bus_b.wdata = wdata_v[1];
  assign done_w[0]   = bus_a.done;
  assign done_w[1]   = bus_b.done;
  assign rdata_w[0]  = bus_a.rdata;
  assign rdata_w[1]  = bus_b.rdata;
  assign busy_a      = bus_a.busy;

  spi_data_port #(.CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_data_port #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Bus monitor, mode-0 checker and SPI memory model for both instances.
  int          div        [2] = '{2, 1};
  int          nrise      [2] = '{0, 0};
  int          runlen     [2] = '{0, 0};
  int          hilen      [2] = '{0, 0};
  int          gap        [2] = '{0, 0};
  int          viol       [2] = '{0, 0};
  int          done_cnt   [2] = '{0, 0};
  int          done_cyc   [2] = '{0, 0};
  int          start_cyc  [2] = '{0, 0};
  logic [63:0] frame      [2] = '{64'h0, 64'h0};
  logic [63:0] last_frame [2] = '{64'h0, 64'h0};
  logic [63:0] prev_frame [2] = '{64'h0, 64'h0};
  logic        psclk      [2] = '{1'b0, 1'b0};
  logic        pcs        [2] = '{1'b1, 1'b1};
  logic        pmosi      [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!cs_n[i]) begin
        if (pcs[i]) begin
          nrise[i]     = 0;
          runlen[i]    = 1;
          frame[i]     = 64'h0;
          gap[i]       = hilen[i];
          start_cyc[i] = cyc;
        end else if (sclk[i] != psclk[i]) begin
          if (runlen[i] != div[i]) viol[i]++;
          runlen[i] = 1;
        end else begin
          runlen[i]++;
        end
        if (sclk[i] && !psclk[i]) begin
          frame[i] = {frame[i][62:0], mosi[i]};
          nrise[i]++;
        end
        if (sclk[i] && psclk[i] && mosi[i] != pmosi[i]) viol[i]++;
        hilen[i] = 0;
      end else begin
        if (!pcs[i]) begin
          prev_frame[i] = last_frame[i];
          last_frame[i] = frame[i];
        end
        hilen[i]++;
      end
      if (!sclk[i] && nrise[i] < 64) miso[i] = resp[i][63 - nrise[i]];
      if (done_w[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      psclk[i] = sclk[i];
      pcs[i]   = cs_n[i];
      pmosi[i] = mosi[i];
    end
  end

  task automatic wait_cnt(input int i, input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt[i] >= target) break;
    end
  endtask

  task automatic run(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [63:0] r, output int lat, output int ndone);
    int base;
    int t0;
    resp[i]    = r;
    we_v[i]    = w;
    addr_v[i]  = a;
    wdata_v[i] = d;
    @(negedge clk);
    base     = done_cnt[i];
    t0       = cyc;
    req_v[i] = 1'b1;
    @(negedge clk);
    req_v[i] = 1'b0;
    wait_cnt(i, base + 1, 400);
    repeat (5) @(negedge clk);
    lat   = (done_cnt[i] > base) ? done_cyc[i] - t0 : -1;
    ndone = done_cnt[i] - base;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int nd;
    int base;
    int d1;

    repeat (3) @(negedge clk);
    chk("reset_pins", {sclk[0], cs_n[0], mosi[0], busy_a, done_w[0]}, 5'b01000);
    chk("reset_rdata", rdata_w[0], 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 1'b0, 32'h0000_1234, 32'h0, {32'h5A5A_A5A5, 32'hEFBE_ADDE}, lat, nd);
    chk("load_latency", lat, 259);
    chk("load_frame_hdr", last_frame[0][63:32], 32'h0300_1234);
    chk("load_rdata", rdata_w[0], 32'hDEAD_BEEF);
    chk("load_done_cnt", nd, 1);

    run(0, 1'b1, 32'h0000_0010, 32'h1122_3344, 64'hFFFF_FFFF_FFFF_FFFF, lat, nd);
    chk("store_latency", lat, 259);
    chk("store_frame", last_frame[0], 64'h0200_0010_4433_2211);
    chk("store_rdata_kept", rdata_w[0], 32'hDEAD_BEEF);
    chk("store_done_cnt", nd, 1);

    run(0, 1'b0, 32'hFF00_0013, 32'hFFFF_FFFF, {32'h0, 32'h0102_0304}, lat, nd);
    chk("unaligned_frame_hdr", last_frame[0][63:32], 32'h0300_0010);
    chk("unaligned_rdata", rdata_w[0], 32'h0403_0201);

    // req held high across two stores; wdata changes while the first is busy
    we_v[0]    = 1'b1;
    addr_v[0]  = 32'h0000_0020;
    wdata_v[0] = 32'hA1B2_C3D4;
    @(negedge clk);
    base     = done_cnt[0];
    req_v[0] = 1'b1;
    @(negedge clk);
    wdata_v[0] = 32'h5566_7788;
    wait_cnt(0, base + 1, 400);
    d1 = done_cyc[0];
    wait_cnt(0, base + 2, 400);
    req_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_done_cnt", done_cnt[0] - base, 2);
    chk("b2b_restart_cyc", start_cyc[0] - d1, 2);
    chk("b2b_gap_ge1", (gap[0] >= 1) ? 1 : 0, 1);
    chk("b2b_second_latency", done_cyc[0] - d1, 260);
    chk("b2b_frame1", prev_frame[0], 64'h0200_0020_D4C3_B2A1);
    chk("b2b_frame2", last_frame[0], 64'h0200_0020_8877_6655);

    // reset in the middle of a load
    resp[0]    = {32'h0, 32'hFFFF_FFFF};
    we_v[0]    = 1'b0;
    addr_v[0]  = 32'h0000_0100;
    @(negedge clk);
    base     = done_cnt[0];
    req_v[0] = 1'b1;
    @(negedge clk);
    req_v[0] = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (nrise[0] >= 30) break;
    end
    chk("rst_reached_bit30", nrise[0], 30);
    rst = 1'b1;
    #1;
    chk("rst_async_pins", {cs_n[0], sclk[0], busy_a}, 3'b100);
    chk("rst_rdata_cleared", rdata_w[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("rst_no_done", done_cnt[0] - base, 0);
    run(0, 1'b0, 32'h0000_0200, 32'h0, {32'h0, 32'h0DF0_FECA}, lat, nd);
    chk("post_rst_latency", lat, 259);
    chk("post_rst_rdata", rdata_w[0], 32'hCAFE_F00D);

    run(1, 1'b0, 32'h0000_0040, 32'h0, {32'hFFFF_0000, 32'h7856_3412}, lat, nd);
    chk("div1_latency", lat, 130);
    chk("div1_frame_hdr", last_frame[1][63:32], 32'h0300_0040);
    chk("div1_rdata", rdata_w[1], 32'h1234_5678);
    chk("div1_done_cnt", nd, 1);
    chk("div1_mode0_viol", viol[1], 0);
    chk("div2_mode0_viol", viol[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
